galaksija_key_sequencer: RTL and testbench

- Replaces the instantaneous UART-to-key-matrix mapping with a timed keystroke scheduler.
- Serial bytes are queued in a small FIFO. Each byte becomes a press / hold / release sequence on the 64-entry Galaksija key matrix, with an optional shift lead-in.
- The CPU reads the matrix through the 0x2000-0x27FF keyboard window.
- Sits between uart_rx and the CPU read-data mux, so the ROM keyboard scan sees every key for a guaranteed minimum time.

---
 rtl/galaksija_key_sequencer_if.sv | 25 ++
 rtl/galaksija_key_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_galaksija_key_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/galaksija_key_sequencer_if.sv
// galaksija_key_sequencer_if
// Groups the serial-byte input, the flush strobe, the CPU keyboard-window
// read port and the key-matrix status outputs of the key sequencer.
//   master : host side (uart_rx / CPU / bench) - drives rx_*, flush, key_rd, key_addr
//   slave  : sequencer side - drives key_out, keys, busy, overflow
interface galaksija_key_sequencer_if;
    logic [7:0]  rx_data;   // received UART byte
    logic        rx_valid;  // one-cycle strobe, rx_data valid
    logic        flush;     // one-cycle strobe, abort and clear
    logic        key_rd;    // CPU keyboard-window read strobe
    logic [5:0]  key_addr;  // CPU addr[5:0], key index
    logic [7:0]  key_out;   // registered key read data
    logic [63:0] keys;      // current key-down vector
    logic        busy;      // FSM active or FIFO non-empty
    logic        overflow;  // sticky byte-dropped flag

    modport master (
        output rx_data, rx_valid, flush, key_rd, key_addr,
        input  key_out, keys, busy, overflow
    );
    modport slave (
        input  rx_data, rx_valid, flush, key_rd, key_addr,
        output key_out, keys, busy, overflow
    );
endinterface

// File: rtl/galaksija_key_sequencer.sv
// galaksija_key_sequencer
// Timed keystroke scheduler between uart_rx and the CPU keyboard window.
// Received bytes are queued in a FIFO; each is decoded to a Galaksija
// key-matrix index and played out as an optional shift lead-in, a press
// held for HOLD_CYCLES, and a release gap of GAP_CYCLES.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous, active-low reset
//   bus      : galaksija_key_sequencer_if.slave (rx byte, flush, CPU read
//              port, keys / busy / overflow status)
// Optional feature macro: KEYSEQ_RAW_EN - bytes 0x80-0xBF press the key
// given by byte[5:0] directly; otherwise bytes >= 0x80 are discarded.
module galaksija_key_sequencer #(
    parameter int HOLD_CYCLES  = 1000000,
    parameter int GAP_CYCLES   = 500000,
    parameter int SHIFT_CYCLES = 250000,
    parameter int FIFO_AW      = 4
) (
    input  logic clk,
    input  logic reset_n,
    galaksija_key_sequencer_if.slave bus
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXC   = (MAX_HG > SHIFT_CYCLES) ? MAX_HG : SHIFT_CYCLES;
    // Loaded values never exceed MAXC-1.
    localparam int TW     = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] SHIFT_LD = TW'(SHIFT_CYCLES - 1);
    localparam int SHIFT_KEY = 53;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_SHIFT_PRE, S_PRESS, S_RELEASE} state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_mem [0:DEPTH-1];
    logic [FIFO_AW:0] r_wr, r_rd;       // extra MSB separates full from empty
    logic [TW-1:0]   r_timer, w_ld_val;
    logic            w_ld;
    logic [63:0]     r_keys, w_keys_nxt;
    logic [7:0]      r_key_out;
    logic            r_overflow;
    logic [5:0]      r_idx, w_sel_idx;
    logic            r_shift, w_sel_shift;
    logic            w_empty, w_full, w_pop, w_push;
    logic [7:0]      w_head;
    logic            w_dec_valid, w_dec_shift;
    logic [5:0]      w_dec_idx;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[FIFO_AW] != r_rd[FIFO_AW]) &&
                     (r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0]);
    assign w_head  = r_mem[r_rd[FIFO_AW-1:0]];
    assign w_pop   = (r_state == S_LOOKUP) && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = bus.rx_valid && !bus.flush && (!w_full || w_pop);

    // Byte to {valid, shift, idx} decode on the FIFO head.
    always_comb begin
        w_dec_valid = 1'b0;
        w_dec_shift = 1'b0;
        w_dec_idx   = 6'd0;
        if (w_head >= 8'h41 && w_head <= 8'h5A) begin
            w_dec_valid = 1'b1; w_dec_idx = 6'(w_head - 8'h40);
        end else if (w_head >= 8'h61 && w_head <= 8'h7A) begin
            w_dec_valid = 1'b1; w_dec_idx = 6'(w_head - 8'h60);
        end else if (w_head >= 8'h30 && w_head <= 8'h39) begin
            w_dec_valid = 1'b1; w_dec_idx = 6'(w_head - 8'h10);
        end else begin
            w_dec_valid = 1'b1;
            w_dec_shift = 1'b1;
            case (w_head)
                8'h0D, 8'h0A: begin w_dec_idx = 6'd48; w_dec_shift = 1'b0; end
                8'h08, 8'h7F: begin w_dec_idx = 6'd29; w_dec_shift = 1'b0; end
                8'h1B: begin w_dec_idx = 6'd49; w_dec_shift = 1'b0; end
                8'h20: begin w_dec_idx = 6'd31; w_dec_shift = 1'b0; end
                8'h5F: w_dec_idx = 6'd32;  // _
                8'h21: w_dec_idx = 6'd33;  // !
                8'h22: w_dec_idx = 6'd34;  // "
                8'h23: w_dec_idx = 6'd35;  // #
                8'h24: w_dec_idx = 6'd36;  // $
                8'h25: w_dec_idx = 6'd37;  // %
                8'h26: w_dec_idx = 6'd38;  // &
                8'h5C: w_dec_idx = 6'd39;  // backslash
                8'h28: w_dec_idx = 6'd40;  // (
                8'h29: w_dec_idx = 6'd41;  // )
                8'h2B: w_dec_idx = 6'd42;  // +
                8'h2A: w_dec_idx = 6'd43;  // *
                8'h3C: w_dec_idx = 6'd44;  // <
                8'h2D: w_dec_idx = 6'd45;  // -
                8'h3E: w_dec_idx = 6'd46;  // >
                8'h3F: w_dec_idx = 6'd47;  // ?
                8'h3B: begin w_dec_idx = 6'd42; w_dec_shift = 1'b0; end
                8'h3A: begin w_dec_idx = 6'd43; w_dec_shift = 1'b0; end
                8'h2C: begin w_dec_idx = 6'd44; w_dec_shift = 1'b0; end
                8'h3D: begin w_dec_idx = 6'd45; w_dec_shift = 1'b0; end
                8'h2E: begin w_dec_idx = 6'd46; w_dec_shift = 1'b0; end
                8'h2F: begin w_dec_idx = 6'd47; w_dec_shift = 1'b0; end
                default: begin w_dec_valid = 1'b0; w_dec_shift = 1'b0; end
            endcase
        end
`ifdef KEYSEQ_RAW_EN
        if (w_head[7:6] == 2'b10) begin
            w_dec_valid = 1'b1;
            w_dec_shift = 1'b0;
            w_dec_idx   = w_head[5:0];
        end
`endif
    end

    // Next state, timer load and next key vector.
    always_comb begin
        w_next   = r_state;
        w_ld     = 1'b0;
        w_ld_val = '0;
        case (r_state)
            S_IDLE: if (!w_empty) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (!w_dec_valid || w_empty) begin
                    w_next = S_IDLE;
                end else if (w_dec_shift) begin
                    w_next = S_SHIFT_PRE; w_ld = 1'b1; w_ld_val = SHIFT_LD;
                end else begin
                    w_next = S_PRESS; w_ld = 1'b1; w_ld_val = HOLD_LD;
                end
            end
            S_SHIFT_PRE: if (r_timer == '0) begin
                w_next = S_PRESS; w_ld = 1'b1; w_ld_val = HOLD_LD;
            end
            S_PRESS: if (r_timer == '0) begin
                w_next = S_RELEASE; w_ld = 1'b1; w_ld_val = GAP_LD;
            end
            S_RELEASE: if (r_timer == '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        // Leaving LOOKUP the decode is not latched yet, so use it directly.
        w_sel_idx   = (r_state == S_LOOKUP) ? w_dec_idx   : r_idx;
        w_sel_shift = (r_state == S_LOOKUP) ? w_dec_shift : r_shift;
        w_keys_nxt  = '0;
        case (w_next)
            S_SHIFT_PRE: w_keys_nxt[SHIFT_KEY] = 1'b1;
            S_PRESS: begin
                w_keys_nxt[w_sel_idx] = 1'b1;
                if (w_sel_shift) w_keys_nxt[SHIFT_KEY] = 1'b1;
            end
            default: w_keys_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[FIFO_AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || bus.flush) begin
            r_state    <= S_IDLE;
            r_wr       <= '0;
            r_rd       <= '0;
            r_timer    <= '0;
            r_keys     <= '0;
            r_overflow <= 1'b0;
            r_idx      <= 6'd0;
            r_shift    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_keys  <= w_keys_nxt;
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (bus.rx_valid && !w_push) r_overflow <= 1'b1;
            if (r_state == S_LOOKUP) begin
                r_idx   <= w_dec_idx;
                r_shift <= w_dec_shift;
            end
            if (w_ld)                r_timer <= w_ld_val;
            else if (r_timer != '0)  r_timer <= r_timer - 1'b1;
        end
    end

    // Active-low key read: FE when the addressed key is down.
    always_ff @(posedge clk) begin
        if (!reset_n)        r_key_out <= 8'hFF;
        else if (bus.key_rd) r_key_out <= r_keys[bus.key_addr] ? 8'hFE : 8'hFF;
    end

    assign bus.keys     = r_keys;
    assign bus.key_out  = r_key_out;
    assign bus.busy     = (r_state != S_IDLE) || !w_empty;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_galaksija_key_sequencer.sv
// tb_galaksija_key_sequencer
// Directed bench for galaksija_key_sequencer with HOLD=8, GAP=4, SHIFT=2,
// FIFO_AW=2. Expected key vectors come from a small timeline model keyed
// on the LOOKUP cycle of each keystroke. Cycle c counts clock edges from
// the edge that pushes the first byte of a scenario (c=1).
module tb_galaksija_key_sequencer;
    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int SHF  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    galaksija_key_sequencer_if bus_if();

    galaksija_key_sequencer #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .SHIFT_CYCLES(SHF), .FIFO_AW(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if.slave)
    );

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.flush    = 1'b0;
        bus_if.key_rd   = 1'b0;
        bus_if.key_addr = 6'd0;
    endtask

    // Expected keys at cycle c for a keystroke whose LOOKUP is cycle t0.
    function automatic logic [63:0] stroke(int c, int t0, int idx, bit sh);
        logic [63:0] k;
        int p0;
        k  = '0;
        p0 = sh ? t0 + 1 + SHF : t0 + 1;
        if (sh && c > t0 && c < p0) k[53] = 1'b1;
        if (c >= p0 && c < p0 + HOLD) begin
            k[idx] = 1'b1;
            if (sh) k[53] = 1'b1;
        end
        return k;
    endfunction

    task automatic test_reset;
        idle_inputs();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (bus_if.keys !== 64'd0) begin n_err++; $display("FAIL reset_keys got=%h exp=0", bus_if.keys); end
        n_cmp++; if (bus_if.key_out !== 8'hFF) begin n_err++; $display("FAIL reset_key_out got=%h exp=ff", bus_if.key_out); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        n_cmp++; if (bus_if.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", bus_if.overflow); end
        // Reset in the middle of a press.
        bus_if.rx_data = 8'h41; bus_if.rx_valid = 1'b1;
        tick();
        bus_if.rx_valid = 1'b0;
        tick(); tick();
        bus_if.key_rd = 1'b1; bus_if.key_addr = 6'd1;
        tick();
        bus_if.key_rd = 1'b0;
        n_cmp++; if (bus_if.key_out !== 8'hFE) begin n_err++; $display("FAIL midreset_pre_key_out got=%h exp=fe", bus_if.key_out); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++; if (bus_if.keys !== 64'd0) begin n_err++; $display("FAIL midreset_keys got=%h exp=0", bus_if.keys); end
        n_cmp++; if (bus_if.key_out !== 8'hFF) begin n_err++; $display("FAIL midreset_key_out got=%h exp=ff", bus_if.key_out); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got=%b exp=0", bus_if.busy); end
        tick();
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy2 got=%b exp=0", bus_if.busy); end
    endtask

    task automatic test_plain_key;
        logic [63:0] ek;
        bus_if.rx_data = 8'h41; bus_if.rx_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus_if.rx_valid = 1'b0;
            ek = stroke(c, 2, 1, 1'b0);
            n_cmp++; if (bus_if.keys !== ek) begin n_err++; $display("FAIL plain_keys c=%0d got=%h exp=%h", c, bus_if.keys, ek); end
            n_cmp++; if (bus_if.busy !== (c <= 14)) begin n_err++; $display("FAIL plain_busy c=%0d got=%b exp=%b", c, bus_if.busy, c <= 14); end
            if (c == 5) begin
                n_cmp++; if (bus_if.key_out !== 8'hFE) begin n_err++; $display("FAIL plain_keyrd_1 got=%h exp=fe", bus_if.key_out); end
            end
            if (c == 6 || c == 7) begin
                n_cmp++; if (bus_if.key_out !== 8'hFF) begin n_err++; $display("FAIL plain_keyrd_2 c=%0d got=%h exp=ff", c, bus_if.key_out); end
            end
            bus_if.key_rd = (c == 4 || c == 5);
            bus_if.key_addr = (c == 5) ? 6'd2 : 6'd1;
        end
        bus_if.key_rd = 1'b0;
    endtask

    task automatic test_shifted_key;
        logic [63:0] ek;
        bus_if.rx_data = 8'h21; bus_if.rx_valid = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            bus_if.rx_valid = 1'b0;
            ek = stroke(c, 2, 33, 1'b1);
            n_cmp++; if (bus_if.keys !== ek) begin n_err++; $display("FAIL shift_keys c=%0d got=%h exp=%h", c, bus_if.keys, ek); end
            n_cmp++; if (bus_if.busy !== (c <= 16)) begin n_err++; $display("FAIL shift_busy c=%0d got=%b exp=%b", c, bus_if.busy, c <= 16); end
        end
    endtask

    task automatic test_overflow;
        logic [63:0] ek;
        logic [7:0]  b;
        bus_if.rx_data = 8'h41; bus_if.rx_valid = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            tick();
            ek = stroke(c, 2, 1, 1'b0) | stroke(c, 16, 33, 1'b0) | stroke(c, 30, 34, 1'b0)
               | stroke(c, 44, 35, 1'b0) | stroke(c, 58, 36, 1'b0);
            n_cmp++; if (bus_if.keys !== ek) begin n_err++; $display("FAIL ovf_keys c=%0d got=%h exp=%h", c, bus_if.keys, ek); end
            n_cmp++; if (bus_if.busy !== (c <= 70)) begin n_err++; $display("FAIL ovf_busy c=%0d got=%b exp=%b", c, bus_if.busy, c <= 70); end
            n_cmp++; if (bus_if.overflow !== (c >= 8)) begin n_err++; $display("FAIL ovf_flag c=%0d got=%b exp=%b", c, bus_if.overflow, c >= 8); end
            // Bytes "1".."6" pushed on edges 4..9, all during PRESS of "A".
            b = 8'h31 + 8'(c - 3);
            bus_if.rx_valid = (c >= 3 && c <= 8);
            bus_if.rx_data  = b;
        end
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic test_unmapped_flush;
        logic [63:0] ek;
        logic        eb;
        bus_if.rx_data = 8'h7E; bus_if.rx_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus_if.rx_valid = 1'b0;
            bus_if.flush    = 1'b0;
            ek = (c == 6 || c == 7) ? (64'd1 << 26) : 64'd0;
            eb = (c <= 2) || (c >= 4 && c <= 7);
            n_cmp++; if (bus_if.keys !== ek) begin n_err++; $display("FAIL unm_keys c=%0d got=%h exp=%h", c, bus_if.keys, ek); end
            n_cmp++; if (bus_if.busy !== eb) begin n_err++; $display("FAIL unm_busy c=%0d got=%b exp=%b", c, bus_if.busy, eb); end
            n_cmp++; if (bus_if.overflow !== (c < 8)) begin n_err++; $display("FAIL unm_overflow c=%0d got=%b exp=%b", c, bus_if.overflow, c < 8); end
            if (c == 3) begin bus_if.rx_data = 8'h5A; bus_if.rx_valid = 1'b1; end
            // Flush with a simultaneous byte: byte must be discarded.
            if (c == 7) begin bus_if.flush = 1'b1; bus_if.rx_data = 8'h42; bus_if.rx_valid = 1'b1; end
        end
    endtask

    task automatic test_raw_key;
        logic [63:0] ek;
        logic        eb;
        bus_if.rx_data = 8'hB5; bus_if.rx_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus_if.rx_valid = 1'b0;
`ifdef KEYSEQ_RAW_EN
            ek = stroke(c, 2, 53, 1'b0);
            eb = (c <= 14);
`else
            ek = 64'd0;
            eb = (c <= 2);
`endif
            n_cmp++; if (bus_if.keys !== ek) begin n_err++; $display("FAIL raw_keys c=%0d got=%h exp=%h", c, bus_if.keys, ek); end
            n_cmp++; if (bus_if.busy !== eb) begin n_err++; $display("FAIL raw_busy c=%0d got=%b exp=%b", c, bus_if.busy, eb); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_plain_key();
        test_shifted_key();
        test_overflow();
        test_unmapped_flush();
        test_raw_key();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
